mod_updown_counter: RTL

Parametrised modulo up/down counter: the next generation of the 5-bit up/down counter in the datapath control section. It adds a programmable modulus, wrap-or-saturate mode, synchronous parallel load with range checking, a synchronous clear, a registered wrap pulse and a sticky error flag. Intended uses are loop and address counters in the controller, where the count range is not a power of two.

---
 rtl/mod_updown_counter_pkg.sv | 7 +
 rtl/mod_updown_counter_step.sv | 25 ++
 rtl/mod_updown_counter.sv | 56 +++++
 3 files changed

// File: rtl/mod_updown_counter_pkg.sv
// mod_updown_counter_pkg: shared direction and boundary-mode constants
package mod_updown_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
endpackage

// File: rtl/mod_updown_counter_step.sv
// mod_step_unit: combinational +/-1 step with modulo wrap or saturation
module mod_step_unit
  import mod_updown_counter_pkg::*;
#(
  parameter int SIZE = 5,
  parameter int MOD = 32
) (
  input  logic [SIZE-1:0] q,
  input  logic            dir,
  input  logic            sat,
  output logic [SIZE-1:0] nxt,
  output logic            bnd
);
  localparam logic [SIZE:0] MOD_W = (SIZE+1)'(MOD);
  localparam logic [SIZE-1:0] LAST = SIZE'(MOD - 1);
  logic [SIZE:0] op;
  logic [SIZE:0] sum;
  // one extra bit: up-step hits MOD exactly at the top, down-step borrows into it at zero
  always_comb begin
    op = (dir == DIR_UP) ? (SIZE+1)'(1) : '1;
    sum = {1'b0, q} + op;
    bnd = (dir == DIR_UP) ? (sum == MOD_W) : sum[SIZE];
    nxt = !bnd ? sum[SIZE-1:0] : (sat == MODE_SAT) ? q : (dir == DIR_UP) ? '0 : LAST;
  end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo up/down counter with load range check, wrap pulse and sticky error
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int SIZE = 5,
  parameter int MOD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            dir,
  input  logic            sat,
  input  logic            load,
  input  logic [SIZE-1:0] parIn,
  output logic [SIZE-1:0] count,
  output logic            bout_up,
  output logic            bout_down,
  output logic            wrap,
  output logic            err
);
  localparam logic [SIZE:0] LAST_W = (SIZE+1)'(MOD - 1);
  if (MOD < 2 || MOD > (1 << SIZE)) begin : g_bad_mod
    $error("mod_updown_counter: MOD out of range 2..2**SIZE");
  end
  logic [SIZE-1:0] step_nxt;
  logic [SIZE-1:0] count_nxt;
  logic step_bnd;
  logic in_range;
  mod_step_unit #(.SIZE(SIZE), .MOD(MOD)) u_step (
    .q(count),
    .dir(dir),
    .sat(sat),
    .nxt(step_nxt),
    .bnd(step_bnd)
  );
  always_comb begin
    in_range = {1'b0, parIn} <= LAST_W;
    count_nxt = clr ? '0 : load ? (in_range ? parIn : LAST_W[SIZE-1:0]) : en ? step_nxt : count;
  end
  for (genvar i = 0; i < SIZE; i++) begin : g_reg
    always_ff @(posedge clk)
      count[i] <= rst ? 1'b0 : count_nxt[i];
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrap <= 1'b0;
      err <= 1'b0;
    end else begin
      wrap <= !load && en && step_bnd;
      err <= err || (load && !in_range);
    end
  end
  assign bout_up = count == LAST_W[SIZE-1:0];
  assign bout_down = count == '0;
endmodule
